// File: rtl/adc108s102_pkg.sv
// Shared constants and FSM state type for the ADC108S102 responder.
// Latency and backpressure: none, declarations only.
package adc108s102_pkg;
    localparam int DATA_W          = 10;
    localparam int NCH             = 8;
    localparam int CH_W            = 3;
    localparam int FRAME_BITS      = 16;
    localparam int CNT_W           = 5;
    localparam int LEAD_ZEROS      = 4;
    localparam int TRAIL_ZEROS     = 2;
    localparam int ADDR_FIRST_EDGE = 3;
    localparam int ADDR_LAST_EDGE  = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;
endpackage

// File: rtl/adc108s102_responder_sync_edge_det.sv
// Synchronizer for one master-side pin plus rise/fall pulses taken from its last stage.
// Latency: STAGES cycles to the pulses; backpressure: none, pulses are never held.
module sync_edge_det #(
    parameter int   STAGES   = 2,
    parameter logic IDLE_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q;
    logic              last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{IDLE_VAL}};
            last_q <= IDLE_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            last_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~last_q;
    assign fall = ~sync_q[STAGES-1] & last_q;
endmodule

// File: rtl/adc108s102_responder.sv
// Converter side of the ADC108S102 link: serves 16-bit DOUT frames from ch_data, decodes the next channel from DIN.
// Latency: SYNC_STAGES+1 clk from pin edge to dout/dout_oe; backpressure: none, the master paces everything via SCLK/CS_N.
module adc108s102_responder
    import adc108s102_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH*DATA_W-1:0]    ch_data,
    input  logic                     sclk,
    input  logic                     cs_n,
    input  logic                     din,
    output logic                     dout,
    output logic                     dout_oe,
    output logic [CH_W-1:0]          cur_ch,
    output logic                     frame_done,
    output logic                     frame_err
);
    localparam logic [CNT_W-1:0] LAST_RISE = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] A_FIRST   = CNT_W'(ADDR_FIRST_EDGE);
    localparam logic [CNT_W-1:0] A_LAST    = CNT_W'(ADDR_LAST_EDGE);

    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] din_sync;
    logic                   din_s;
    state_t                 state;
    logic [FRAME_BITS-1:0]  shreg;
    logic [FRAME_BITS-1:0]  frame_word;
    logic [DATA_W-1:0]      sample;
    logic [CNT_W-1:0]       rise_cnt, rise_nxt;
    logic [CH_W-1:0]        addr_nxt;

    sync_edge_det #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sclk_det (
        .clk  (clk),
        .rst  (rst),
        .d    (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_cs_det (
        .clk  (clk),
        .rst  (rst),
        .d    (cs_n),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // Same depth as the edge detectors so din lines up with the sclk_rise it belongs to.
    always_ff @(posedge clk) begin
        if (rst) din_sync <= '0;
        else     din_sync <= {din_sync[SYNC_STAGES-2:0], din};
    end
    assign din_s = din_sync[SYNC_STAGES-1];

    assign sample     = ch_data[int'(cur_ch)*DATA_W +: DATA_W];
    assign frame_word = {{LEAD_ZEROS{1'b0}}, sample, {TRAIL_ZEROS{1'b0}}};
    assign rise_nxt   = (rise_cnt == LAST_RISE) ? rise_cnt : rise_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            rise_cnt   <= '0;
            addr_nxt   <= '0;
            cur_ch     <= '0;
            dout       <= 1'b0;
            dout_oe    <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        shreg    <= frame_word;
                        dout     <= frame_word[FRAME_BITS-1];
                        dout_oe  <= 1'b1;
                        rise_cnt <= '0;
                        addr_nxt <= '0;
                        state    <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // A CS_N edge takes priority over any SCLK edge seen in the same cycle.
                    if (cs_rise) begin
                        frame_err <= 1'b1;
                        dout_oe   <= 1'b0;
                        dout      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        if (sclk_fall) begin
                            shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
                            dout  <= shreg[FRAME_BITS-2];
                        end
                        if (sclk_rise) begin
                            rise_cnt <= rise_nxt;
                            if (rise_nxt >= A_FIRST && rise_nxt <= A_LAST)
                                addr_nxt <= {addr_nxt[CH_W-2:0], din_s};
                            if (rise_nxt == LAST_RISE) begin
                                dout  <= 1'b0;
                                state <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    if (cs_rise) begin
                        cur_ch     <= addr_nxt;
                        frame_done <= 1'b1;
                        dout_oe    <= 1'b0;
                        dout       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc108s102_responder.sv
// Bench for adc108s102_responder: directed frames with literal expectations, then randomized frames
// checked every cycle against a pin-level frame model delayed by the synchronizer latency.
module tb_adc108s102_responder;
    localparam int S = 2;

    typedef struct packed {
        logic       dout;
        logic       oe;
        logic [2:0] ch;
        logic       done;
        logic       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [79:0] ch_data = '0;
    logic        sclk = 1'b1;
    logic        cs_n = 1'b1;
    logic        din = 1'b0;
    logic        dout, dout_oe, frame_done, frame_err;
    logic [2:0]  cur_ch;

    int n_tests = 0;
    int n_fail = 0;
    int n_cyc_fail_prints = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    adc108s102_responder #(.SYNC_STAGES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .ch_data    (ch_data),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .din        (din),
        .dout       (dout),
        .dout_oe    (dout_oe),
        .cur_ch     (cur_ch),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    // Frame model on the raw pins; pipe[S] holds what the outputs must show after the sync delay.
    bit          started = 1'b0;
    bit          prev_cs = 1'b1, prev_sclk = 1'b1;
    bit          m_in = 1'b0;
    int          m_rises = 0, m_falls = 0, m_addr = 0;
    logic [15:0] m_word = '0;
    logic        m_dout = 1'b0, m_oe = 1'b0;
    logic [2:0]  m_ch = '0;
    exp_t        pipe [S+1];

    always @(posedge clk) begin
        bit cs_f, cs_r, sk_f, sk_r, y_done, y_err;
        if (rst) begin
            started = 1'b1;
            prev_cs = 1'b1; prev_sclk = 1'b1;
            m_in = 1'b0; m_oe = 1'b0; m_dout = 1'b0; m_ch = '0;
            for (int i = 0; i <= S; i++) pipe[i] = '0;
        end else begin
            cs_f = prev_cs && !cs_n;
            cs_r = !prev_cs && cs_n;
            sk_f = prev_sclk && !sclk;
            sk_r = !prev_sclk && sclk;
            prev_cs = cs_n; prev_sclk = sclk;
            y_done = 1'b0; y_err = 1'b0;
            if (cs_r) begin
                if (m_in) begin
                    if (m_rises >= 16) begin m_ch = 3'(m_addr); y_done = 1'b1; end
                    else y_err = 1'b1;
                    m_in = 1'b0; m_oe = 1'b0; m_dout = 1'b0;
                end
            end else if (cs_f) begin
                if (!m_in) begin
                    m_in = 1'b1; m_rises = 0; m_falls = 0; m_addr = 0;
                    m_word = {4'b0000, ch_data[int'(m_ch)*10 +: 10], 2'b00};
                    m_oe = 1'b1; m_dout = m_word[15];
                end
            end else if (m_in && m_rises < 16) begin
                if (sk_f) begin
                    m_falls++;
                    m_dout = (m_falls < 16) ? m_word[15-m_falls] : 1'b0;
                end
                if (sk_r) begin
                    m_rises++;
                    if (m_rises >= 3 && m_rises <= 5) m_addr = m_addr * 2 + int'(din);
                    if (m_rises == 16) m_dout = 1'b0;
                end
            end
            for (int i = S; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = '{dout: m_dout, oe: m_oe, ch: m_ch, done: y_done, err: y_err};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every wait in the bench goes through here, so the per-cycle compare sees every cycle.
    task automatic tick(input int n);
        exp_t a;
        repeat (n) begin
            @(negedge clk);
            if (frame_done === 1'b1) done_cnt++;
            if (frame_err === 1'b1) err_cnt++;
            if (started) begin
                a = '{dout: dout, oe: dout_oe, ch: cur_ch, done: frame_done, err: frame_err};
                n_tests++;
                if (a !== pipe[S]) begin
                    n_fail++;
                    if (n_cyc_fail_prints < 30) begin
                        n_cyc_fail_prints++;
                        $display("FAIL cycle {dout,oe,ch,done,err}: got %b expected %b at %0t", a, pipe[S], $time);
                    end
                end
            end
        end
    endtask

    task automatic run_frame(input logic [2:0] addr, input int nclk, input int h, input bit coincide,
                             input int chg_at, input logic [79:0] chg_val, input int rst_at,
                             output logic [15:0] word, output logic oe_late);
        word = '0;
        oe_late = 1'b1;
        cs_n = 1'b0; sclk = 1'b1;
        tick(h);
        for (int i = 1; i <= nclk; i++) begin
            if (i == rst_at) begin
                rst = 1'b1; cs_n = 1'b1; sclk = 1'b1;
                tick(1);
                check("rst_mid dout", 32'(dout), 0);
                check("rst_mid dout_oe", 32'(dout_oe), 0);
                check("rst_mid cur_ch", 32'(cur_ch), 0);
                check("rst_mid frame_done", 32'(frame_done), 0);
                check("rst_mid frame_err", 32'(frame_err), 0);
                rst = 1'b0;
                tick(h + 4);
                return;
            end
            if (i == chg_at) ch_data = chg_val;
            if (i <= 16) word = {word[14:0], dout};
            sclk = 1'b0;
            din = (i == 3) ? addr[2] : (i == 4) ? addr[1] : (i == 5) ? addr[0] : 1'($urandom_range(0, 1));
            tick(h);
            sclk = 1'b1;
            if (coincide && i == nclk) cs_n = 1'b1;
            tick(h);
        end
        cs_n = 1'b1; sclk = 1'b1;
        tick(S + 1);
        oe_late = dout_oe;
        tick(2 * h + 2);
    endtask

    initial begin
        logic [15:0] w;
        logic        oe_l;
        logic [79:0] nv;
        int          nclk, h;
        bit          co;

        for (int k = 0; k < 8; k++) ch_data[k*10 +: 10] = 10'($urandom);
        ch_data[0*10 +: 10] = 10'h2A5;
        ch_data[5*10 +: 10] = 10'h3FF;
        ch_data[2*10 +: 10] = 10'h001;

        tick(3);
        check("reset dout", 32'(dout), 0);
        check("reset dout_oe", 32'(dout_oe), 0);
        check("reset cur_ch", 32'(cur_ch), 0);
        check("reset frame_done", 32'(frame_done), 0);
        check("reset frame_err", 32'(frame_err), 0);
        rst = 1'b0;
        tick(5);

        run_frame(3'b101, 16, 4, 1'b0, 0, '0, 0, w, oe_l);
        check("f1 word", 32'(w), 32'h0A94);
        check("f1 cur_ch", 32'(cur_ch), 5);
        check("f1 model cur_ch", 32'(m_ch), 5);
        check("f1 done count", 32'(done_cnt), 1);
        check("f1 err count", 32'(err_cnt), 0);

        run_frame(3'b010, 16, 5, 1'b0, 0, '0, 0, w, oe_l);
        check("f2 word", 32'(w), 32'h0FFC);
        check("f2 cur_ch", 32'(cur_ch), 2);

        run_frame(3'b111, 9, 4, 1'b0, 0, '0, 0, w, oe_l);
        check("f3 err count", 32'(err_cnt), 1);
        check("f3 done count", 32'(done_cnt), 2);
        check("f3 cur_ch", 32'(cur_ch), 2);
        check("f3 oe after cs rise", 32'(oe_l), 0);

        run_frame(3'b010, 20, 4, 1'b0, 0, '0, 0, w, oe_l);
        check("f4 word", 32'(w), 32'h0004);
        check("f4 done count", 32'(done_cnt), 3);
        check("f4 cur_ch", 32'(cur_ch), 2);

        nv = ch_data;
        nv[2*10 +: 10] = 10'h200;
        run_frame(3'b110, 16, 4, 1'b0, 6, nv, 0, w, oe_l);
        check("f5 word", 32'(w), 32'h0004);
        check("f5 cur_ch", 32'(cur_ch), 6);

        run_frame(3'b011, 16, 4, 1'b0, 0, '0, 8, w, oe_l);
        check("f6 err count", 32'(err_cnt), 1);
        check("f6 model cur_ch", 32'(m_ch), 0);

        run_frame(3'b001, 16, 4, 1'b0, 0, '0, 0, w, oe_l);
        check("f7 word", 32'(w), 32'h0A94);
        check("f7 cur_ch", 32'(cur_ch), 1);

        for (int f = 0; f < 40; f++) begin
            nv = {$urandom, $urandom, $urandom};
            ch_data = nv;
            nclk = ($urandom_range(0, 9) < 7) ? 16 : int'($urandom_range(0, 20));
            h = int'($urandom_range(4, 6));
            co = ($urandom_range(0, 4) == 0);
            run_frame(3'($urandom), nclk, h, co, 0, '0, 0, w, oe_l);
            check("rand oe after cs rise", 32'(oe_l), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
